// File: rtl/divisor_feeder_if.sv
// divisor_feeder_if: operand stream, divider start/done link and result stream.
// slave is the feeder's view, master is the surrounding environment's view.
interface divisor_feeder_if #(
  parameter int size = 8
);
  logic            in_valid;
  logic            in_ready;
  logic [size-1:0] in_num;
  logic [size-1:0] in_den;
  logic            start;
  logic [size-1:0] numerador;
  logic [size-1:0] denominador;
  logic [size-1:0] cociente;
  logic [size-1:0] resto;
  logic            done;
  logic            out_valid;
  logic            out_ready;
  logic [size-1:0] out_cociente;
  logic [size-1:0] out_resto;
  logic            out_dz;

  modport slave (
    input  in_valid, in_num, in_den,
    input  cociente, resto, done,
    input  out_ready,
    output in_ready, start,
    output numerador, denominador,
    output out_valid, out_cociente,
    output out_resto, out_dz
  );

  modport master (
    output in_valid, in_num, in_den,
    output cociente, resto, done,
    output out_ready,
    input  in_ready, start,
    input  numerador, denominador,
    input  out_valid, out_cociente,
    input  out_resto, out_dz
  );
endinterface

// File: rtl/divisor_feeder.sv
// divisor_feeder: operand FIFO, issue FSM and result register for the divider.
// Define DIV_ZERO_BYPASS_EN to answer x/0 locally without using the divider.
module divisor_feeder #(
  parameter int size  = 8,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  divisor_feeder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t state, state_n;

  logic [size-1:0] num_mem [DEPTH];
  logic [size-1:0] den_mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;

  logic [size-1:0] head_num, head_den;
  logic            in_ready;
  logic            push, pop;
  logic            out_free;
  logic            load, cap, dz_take;

  logic            start_q;
  logic [size-1:0] num_q, den_q;
  logic            valid_q;
  logic [size-1:0] q_q, r_q;

  assign head_num = num_mem[rd_ptr];
  assign head_den = den_mem[rd_ptr];
  assign in_ready = (count != CW'(DEPTH));
  assign push     = bus.in_valid & in_ready;
  assign pop      = cap | dz_take;
  assign out_free = ~valid_q | bus.out_ready;

  always_comb begin
    state_n = state;
    load    = 1'b0;
    cap     = 1'b0;
    dz_take = 1'b0;
    unique case (state)
      IDLE: begin
        if (count != '0 && out_free) begin
`ifdef DIV_ZERO_BYPASS_EN
          if (head_den == '0) begin
            dz_take = 1'b1;
          end else begin
            state_n = ISSUE;
            load    = 1'b1;
          end
`else
          state_n = ISSUE;
          load    = 1'b1;
`endif
        end
      end
      ISSUE: state_n = WAIT;
      WAIT: begin
        if (bus.done) begin
          cap     = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      start_q <= 1'b0;
      num_q   <= '0;
      den_q   <= '0;
    end else begin
      state   <= state_n;
      start_q <= (state_n == ISSUE);
      if (load) begin
        num_q <= head_num;
        den_q <= head_den;
      end
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      num_mem[wr_ptr] <= bus.in_num;
      den_mem[wr_ptr] <= bus.in_den;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
    end else if (cap) begin
      valid_q <= 1'b1;
      q_q     <= bus.cociente;
      r_q     <= bus.resto;
    end else if (dz_take) begin
      valid_q <= 1'b1;
      q_q     <= '1;
      r_q     <= head_num;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

`ifdef DIV_ZERO_BYPASS_EN
  logic dz_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dz_q <= 1'b0;
    end else if (cap) begin
      dz_q <= 1'b0;
    end else if (dz_take) begin
      dz_q <= 1'b1;
    end
  end

  assign bus.out_dz = dz_q;
`else
  assign bus.out_dz = 1'b0;
`endif

  assign bus.in_ready     = in_ready;
  assign bus.start        = start_q;
  assign bus.numerador    = num_q;
  assign bus.denominador  = den_q;
  assign bus.out_valid    = valid_q;
  assign bus.out_cociente = q_q;
  assign bus.out_resto    = r_q;
endmodule

// File: tb/tb_divisor_feeder.sv
// tb_divisor_feeder: directed vectors plus hand sequences for divisor_feeder,
// with a fixed-latency behavioural divider answering start/done.
module tb_divisor_feeder;
  localparam int W   = 8;
  localparam int LAT = 4;
`ifdef DIV_ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] num;
    logic [W-1:0] den;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         zero;
  } vec_t;

  logic clk;
  logic rst_n;
  logic model_done;
  logic spur_done;
  int   applied;
  int   miscompares;
  int   starts;

  divisor_feeder_if #(.size(W)) sig ();

  divisor_feeder #(
    .size (W),
    .DEPTH(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (sig.slave)
  );

  assign sig.done = model_done | spur_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sig.start === 1'b1) starts <= starts + 1;
  end

  // Behavioural divider: x/0 returns all-ones quotient and x as remainder.
  initial begin
    logic [W-1:0] n, d;
    model_done   = 1'b0;
    sig.cociente = '0;
    sig.resto    = '0;
    forever begin
      @(negedge clk);
      if (sig.start === 1'b1) begin
        n = sig.numerador;
        d = sig.denominador;
        repeat (LAT - 1) @(negedge clk);
        if (d == '0) begin
          sig.cociente = '1;
          sig.resto    = n;
        end else begin
          sig.cociente = n / d;
          sig.resto    = n % d;
        end
        model_done = 1'b1;
        @(negedge clk);
        model_done = 1'b0;
      end
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d",
               name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] n,
                      input logic [W-1:0] d);
    int k;
    k = 0;
    sig.in_valid = 1'b1;
    sig.in_num   = n;
    sig.in_den   = d;
    while (sig.in_ready !== 1'b1 && k < 200) begin
      step();
      k++;
    end
    chk("push_ready", sig.in_ready, 1);
    step();
    sig.in_valid = 1'b0;
  endtask

  task automatic wait_out(input string name);
    int k;
    k = 0;
    while (sig.out_valid !== 1'b1 && k < 200) begin
      step();
      k++;
    end
    chk({name, "_valid"}, sig.out_valid, 1);
  endtask

  task automatic take(input string name,
                      input logic [W-1:0] q,
                      input logic [W-1:0] r);
    wait_out(name);
    chk({name, "_q"}, sig.out_cociente, q);
    chk({name, "_r"}, sig.out_resto, r);
    sig.out_ready = 1'b1;
    step();
    sig.out_ready = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[8];
    vec_t vf[5];
    vec_t vb[3];
    int   s0;

    vt[0] = '{200, 3, 66, 2, 1'b0};
    vt[1] = '{255, 1, 255, 0, 1'b0};
    vt[2] = '{7, 9, 0, 7, 1'b0};
    vt[3] = '{255, 255, 1, 0, 1'b0};
    vt[4] = '{0, 5, 0, 0, 1'b0};
    vt[5] = '{37, 0, 8'hFF, 37, 1'b1};
    vt[6] = '{128, 16, 8, 0, 1'b0};
    vt[7] = '{99, 10, 9, 9, 1'b0};

    vf[0] = '{10, 3, 3, 1, 1'b0};
    vf[1] = '{20, 6, 3, 2, 1'b0};
    vf[2] = '{50, 7, 7, 1, 1'b0};
    vf[3] = '{81, 9, 9, 0, 1'b0};
    vf[4] = '{13, 5, 2, 3, 1'b0};

    vb[0] = '{60, 7, 8, 4, 1'b0};
    vb[1] = '{90, 8, 11, 2, 1'b0};
    vb[2] = '{45, 6, 7, 3, 1'b0};

    applied       = 0;
    miscompares   = 0;
    starts        = 0;
    spur_done     = 1'b0;
    sig.in_valid  = 1'b0;
    sig.in_num    = '0;
    sig.in_den    = '0;
    sig.out_ready = 1'b0;
    rst_n         = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", sig.in_ready, 1);
    chk("rst_start", sig.start, 0);
    chk("rst_num", sig.numerador, 0);
    chk("rst_den", sig.denominador, 0);
    chk("rst_out_valid", sig.out_valid, 0);
    chk("rst_out_q", sig.out_cociente, 0);
    chk("rst_out_r", sig.out_resto, 0);
    chk("rst_out_dz", sig.out_dz, 0);
    rst_n = 1'b1;
    repeat (2) step();

    // Single request: start exactly one cycle after the push edge.
    s0 = starts;
    push(100, 7);
    chk("single_start_e0", sig.start, 0);
    step();
    chk("single_start_e1", sig.start, 1);
    chk("single_num", sig.numerador, 100);
    chk("single_den", sig.denominador, 7);
    step();
    chk("single_start_e2", sig.start, 0);
    wait_out("single");
    repeat (3) step();
    chk("single_hold_valid", sig.out_valid, 1);
    chk("single_hold_q", sig.out_cociente, 14);
    chk("single_dz", sig.out_dz, 0);
    take("single", 14, 2);
    chk("single_drop", sig.out_valid, 0);
    chk("single_starts", starts - s0, 1);

    for (int i = 0; i < 8; i++) begin
      s0 = starts;
      push(vt[i].num, vt[i].den);
      wait_out("vec");
      chk("vec_dz", sig.out_dz, vt[i].zero & BYP);
      chk("vec_starts", starts - s0,
          (vt[i].zero & BYP) ? 0 : 1);
      take("vec", vt[i].q, vt[i].r);
    end

    // Fill: four accepted back-to-back, fifth waits for a completion.
    for (int i = 0; i < 4; i++) begin
      sig.in_valid = 1'b1;
      sig.in_num   = vf[i].num;
      sig.in_den   = vf[i].den;
      step();
    end
    sig.in_valid = 1'b0;
    chk("fill_full", sig.in_ready, 0);
    chk("fill_no_result", sig.out_valid, 0);
    push(vf[4].num, vf[4].den);
    chk("fill_after_done", sig.out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      take("fill", vf[i].q, vf[i].r);
    end

    // Backpressure with three queued; spurious done while stalled.
    s0 = starts;
    for (int i = 0; i < 3; i++) begin
      push(vb[i].num, vb[i].den);
    end
    repeat (30) step();
    chk("bp_valid", sig.out_valid, 1);
    chk("bp_one_start", starts - s0, 1);
    chk("bp_q", sig.out_cociente, vb[0].q);
    spur_done = 1'b1;
    step();
    spur_done = 1'b0;
    repeat (3) step();
    chk("spur_q", sig.out_cociente, vb[0].q);
    chk("spur_r", sig.out_resto, vb[0].r);
    chk("spur_starts", starts - s0, 1);
    chk("spur_in_ready", sig.in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      take("bp", vb[i].q, vb[i].r);
    end
    chk("bp_all_starts", starts - s0, 3);

    // Spurious done with everything idle and empty.
    spur_done = 1'b1;
    step();
    spur_done = 1'b0;
    repeat (3) step();
    chk("idle_spur_valid", sig.out_valid, 0);
    chk("idle_spur_start", sig.start, 0);

    // Reset while waiting on the divider with two more queued.
    push(9, 2);
    push(8, 3);
    push(7, 4);
    chk("wait_num", sig.numerador, 9);
    chk("wait_full_ready", sig.in_ready, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_num", sig.numerador, 0);
    chk("arst_den", sig.denominador, 0);
    chk("arst_start", sig.start, 0);
    chk("arst_valid", sig.out_valid, 0);
    chk("arst_in_ready", sig.in_ready, 1);
    repeat (2) step();
    rst_n = 1'b1;
    s0 = starts;
    repeat (30) step();
    chk("post_rst_valid", sig.out_valid, 0);
    chk("post_rst_starts", starts - s0, 0);
    chk("post_rst_ready", sig.in_ready, 1);

    push(100, 7);
    take("post_rst", 14, 2);

    $display("== %0d vectors applied, %0d miscompares ==",
             applied, miscompares);
    $finish;
  end
endmodule

// File: doc/divisor_feeder.md
# divisor_feeder

Request-buffering front end for the sequential divider. Accepts operand pairs on a valid/ready stream, queues them in a DEPTH-entry FIFO and issues them to the divider one at a time over its start/done handshake. Captures each divider result into an output register and presents it on a valid/ready result stream. Sits directly upstream of the divider and is also the consumer of its `cociente`/`resto`/`done` outputs.

## Interface
- `size`, 8: operand and result width in bits, shared with the divider.
- `DEPTH`, 4: operand FIFO entries; power of two, ≥2.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset. The divider uses the same `clk` and `rst_n`.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  FIFO can accept a pair.
- `in_num`  in  size  dividend.
- `in_den`  in  size  divisor.
- `start`  out  1  one-cycle issue pulse to the divider.
- `numerador`  out  size  dividend to the divider; registered.
- `denominador`  out  size  divisor to the divider; registered.
- `cociente`  in  size  quotient from the divider.
- `resto`  in  size  remainder from the divider.
- `done`  in  1  divider completion pulse.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_cociente`  out  size  captured quotient.
- `out_resto`  out  size  captured remainder.
- `out_dz`  out  1  result came from the divide-by-zero bypass.

## Operation
- FIFO push on a rising edge where `in_valid && in_ready` is true. `in_ready = (count != DEPTH)` is a function of count only, so a pop in the same cycle does not enable a push when the FIFO is full.
- FSM states:
  - IDLE: move to ISSUE when `count > 0` and the output register is free, i.e. `!out_valid || out_ready`.
  - ISSUE: lasts exactly one cycle with `start = 1`, then moves to WAIT.
  - WAIT: on a sampled `done`, capture `cociente`/`resto` into the output register, set `out_valid`, pop the FIFO head and return to IDLE.
- `numerador`/`denominador` load from the FIFO head on the IDLE→ISSUE transition and stay stable until the next issue.
- The head entry is popped only on completion, never on issue.
- `done` sampled in IDLE or ISSUE is ignored.
- Output register:
  - `out_valid` stays high with stable data until `out_ready`.
  - A capture and an `out_ready` in the same cycle are allowed: new data replaces the old and `out_valid` stays 1.
- Simultaneous push and pop when not full: count is unchanged and both take effect.
- FIFO pointers wrap modulo DEPTH. Count is $clog2(DEPTH)+1 bits wide.

## Timing
- Reset values: `in_ready` = 1, `start` = 0, `numerador` = 0, `denominador` = 0, `out_valid` = 0, `out_cociente` = 0, `out_resto` = 0, `out_dz` = 0. FIFO is empty and the FSM is in IDLE.
- Reset asserted mid-operation discards all queued and in-flight requests. No result is produced for them.
- Issue latency: with the FIFO empty and the FSM idle, a push at edge E0 gives `start` high from E1 to E2.
- Result latency: `out_valid` rises at the edge that samples `done` high.
- Back-to-back throughput: the next `start` comes 1 cycle after the completion edge (the IDLE cycle), plus the divider latency.
- All outputs are registered except `in_ready`, which is decoded from the registered count.

## Configuration
- `DIV_ZERO_BYPASS_EN` defined:
  - In IDLE, a head entry with `in_den == 0` and a free output register never goes to the divider.
  - In one cycle the block loads `out_cociente = {size{1'b1}}`, `out_resto = head numerator` and `out_dz = 1`, pops the head, and stays in IDLE.
  - No `start` is generated for that entry.
- `DIV_ZERO_BYPASS_EN` undefined:
  - Zero divisors are issued to the divider like any other pair.
  - `out_dz` is tied to 0.

## Test plan
- Single request: push 100/7 → one `start` pulse one cycle after the push; `out_cociente = 14`, `out_resto = 2`, `out_valid` until `out_ready`.
- Fill with `DEPTH = 4`: push 5 pairs back-to-back, no issue progress yet → `in_ready` drops after 4 accepted. The 5th is accepted only after the first completion. Results come out in order.
- Backpressure: hold `out_ready = 0` with 3 queued → exactly one completed result, no further `start` pulses. Release → remaining pairs issue in order with no loss.
- Divide by zero, 37/0:
  - Macro defined → no `start`; `out_cociente = 0xFF`, `out_resto = 37`, `out_dz = 1` (size 8).
  - Macro undefined → `start` issued and `out_dz = 0`.
- Reset in WAIT: assert `rst_n = 0` while WAIT has 2 entries queued → all outputs go to their reset values asynchronously. After release no result appears and `in_ready = 1`.
- Spurious `done` pulse in IDLE → ignored. FIFO count and `out_valid` unchanged.
